// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the UART receive sniffer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // FIFO entry layout is {parity_err, frame_err, data}.
  function automatic int fifo_entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

  function automatic int uart_cnt_width(input int clk_div);
    return (clk_div > 2) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with flush, occupancy count and sticky overflow.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     overflow_o,
  output logic                     push_ok_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, do_push, do_pop;

  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle; a flush beats both.
  assign do_pop  = pop_i && !empty && !clr_i;
  assign do_push = push_i && !clr_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
      if (push_i && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head is forced to zero while empty so stale storage never leaks out.
  assign rdata_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = !empty;
  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;
  assign push_ok_o  = do_push;

endmodule

// File: rtl/uart_rx_sniffer.sv
// Oversampling UART receive monitor: synchronizer, frame FSM, frame counter and
// a show-ahead FIFO of received characters with per-character error flags.
module uart_rx_sniffer import uart_pkg::*; #(
  parameter int CLK_DIV    = 236,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          clr_i,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic [15:0]                   frame_cnt_o
);

  localparam int CNT_W   = uart_cnt_width(CLK_DIV);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int ENTRY_W = fifo_entry_width(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
  localparam logic             ODD_BIT   = (PARITY_ODD != 0);
  localparam logic             HAS_PAR   = (PARITY_EN != 0);

  logic                 sync1_q, rx_s_q, rx_q;
  uart_rx_state_e       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic                 tick, push, push_ok, pop;
  logic [ENTRY_W-1:0]   push_data, head;

  // Two-flop synchronizer plus one more stage for falling-edge detection; idle is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      rx_q    <= rx_s_q;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    push       = 1'b0;
    if (state_q != IDLE && !tick) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (rx_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s_q) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            cnt_d      = FULL_LOAD;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            shift_d    = '0;
            ferr_d     = 1'b0;
            perr_d     = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) state_d = HAS_PAR ? PARITY : STOP;
          else idx_d = idx_q + 1'b1;
        end
      end
      PARITY: begin
        if (tick) begin
          perr_d  = (^{shift_q, rx_s_q}) ^ ODD_BIT;
          cnt_d   = FULL_LOAD;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          ferr_d = ferr_q | !rx_s_q;
          cnt_d  = FULL_LOAD;
          if (stop_idx_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The last stop sample is folded in directly so the push happens on that same edge.
  assign push_data = {perr_q, ferr_q | !rx_s_q, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (push_ok) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign pop = rx_valid_o && rx_ready_i;

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .push_i     (push),
    .wdata_i    (push_data),
    .pop_i      (pop),
    .rdata_o    (head),
    .valid_o    (rx_valid_o),
    .cnt_o      (fifo_cnt_o),
    .overflow_o (overflow_o),
    .push_ok_o  (push_ok)
  );

  assign rx_data_o    = head[DATA_BITS-1:0];
  assign frame_err_o  = head[DATA_BITS];
  assign parity_err_o = head[DATA_BITS+1];
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Directed bench: an 8N1 instance at 236 clk/bit and an 8O1 instance at 20 clk/bit.
module tb_uart_rx_sniffer;

  localparam int DIV_A = 236;
  localparam int DIV_B = 20;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        rx_a, clr_a, ready_a;
  logic        valid_a, ferr_a, perr_a, ovf_a;
  logic [7:0]  data_a;
  logic [4:0]  fcnt_a;
  logic [15:0] frames_a;

  logic        rx_b, clr_b, ready_b;
  logic        valid_b, ferr_b, perr_b, ovf_b;
  logic [7:0]  data_b;
  logic [4:0]  fcnt_b;
  logic [15:0] frames_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         stop_val;
    logic [7:0] exp_data;
    bit         exp_ferr;
    int         exp_frames;
  } frame_vec_t;

  frame_vec_t vecs [3];
  frame_vec_t vec;

  always #5 clk = ~clk;

  uart_rx_sniffer #(
    .CLK_DIV (DIV_A)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_a),
    .clr_i        (clr_a),
    .rx_valid_o   (valid_a),
    .rx_ready_i   (ready_a),
    .rx_data_o    (data_a),
    .frame_err_o  (ferr_a),
    .parity_err_o (perr_a),
    .overflow_o   (ovf_a),
    .fifo_cnt_o   (fcnt_a),
    .frame_cnt_o  (frames_a)
  );

  uart_rx_sniffer #(
    .CLK_DIV    (DIV_B),
    .PARITY_EN  (1),
    .PARITY_ODD (1)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_b),
    .clr_i        (clr_b),
    .rx_valid_o   (valid_b),
    .rx_ready_i   (ready_b),
    .rx_data_o    (data_b),
    .frame_err_o  (ferr_b),
    .parity_err_o (perr_b),
    .overflow_o   (ovf_b),
    .fifo_cnt_o   (fcnt_b),
    .frame_cnt_o  (frames_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Line changes happen on falling edges so they never race the DUT's sampling edge.
  task automatic driveBit(input bit on_b, input logic v, input int cycles);
    if (on_b) rx_b = v;
    else      rx_a = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic sendFrame(input bit on_b, input logic [7:0] data, input bit use_par,
                           input logic par_bit, input logic stop_val);
    int div;
    div = on_b ? DIV_B : DIV_A;
    driveBit(on_b, 1'b0, div);
    for (int i = 0; i < 8; i++) driveBit(on_b, data[i], div);
    if (use_par) driveBit(on_b, par_bit, div);
    driveBit(on_b, stop_val, div);
    if (on_b) rx_b = 1'b1;
    else      rx_a = 1'b1;
  endtask

  task automatic popA();
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
  endtask

  task automatic applyStimulus(input frame_vec_t v);
    sendFrame(1'b0, v.data, 1'b0, 1'b0, v.stop_val);
    repeat (DIV_A) @(negedge clk);
    checkOutput("vec_valid",  32'(valid_a),  32'd1);
    checkOutput("vec_data",   32'(data_a),   32'(v.exp_data));
    checkOutput("vec_ferr",   32'(ferr_a),   32'(v.exp_ferr));
    checkOutput("vec_perr",   32'(perr_a),   32'd0);
    checkOutput("vec_fcnt",   32'(fcnt_a),   32'd1);
    checkOutput("vec_frames", 32'(frames_a), 32'(v.exp_frames));
    popA();
    checkOutput("vec_popped", 32'(valid_a),  32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 8'h55, 1'b0, 1};
    vecs[1] = '{8'hA3, 1'b0, 8'hA3, 1'b1, 2};
    vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 3};

    rx_a = 1'b1; clr_a = 1'b0; ready_a = 1'b0;
    rx_b = 1'b1; clr_b = 1'b0; ready_b = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid",  32'(valid_a),  32'd0);
    checkOutput("rst_data",   32'(data_a),   32'd0);
    checkOutput("rst_ferr",   32'(ferr_a),   32'd0);
    checkOutput("rst_perr",   32'(perr_a),   32'd0);
    checkOutput("rst_ovf",    32'(ovf_a),    32'd0);
    checkOutput("rst_fcnt",   32'(fcnt_a),   32'd0);
    checkOutput("rst_frames", 32'(frames_a), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    // Short low pulse on an idle line must be rejected at the start-bit sample.
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (300) @(negedge clk);
    checkOutput("glitch_fcnt",   32'(fcnt_a),   32'd0);
    checkOutput("glitch_frames", 32'(frames_a), 32'd3);
    vec = '{8'h81, 1'b1, 8'h81, 1'b0, 4};
    applyStimulus(vec);

    // Odd parity on 0x07 (three ones): parity bit 0 is correct, 1 is an error.
    sendFrame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (DIV_B) @(negedge clk);
    checkOutput("par_ok_valid", 32'(valid_b), 32'd1);
    checkOutput("par_ok_data",  32'(data_b),  32'h07);
    checkOutput("par_ok_perr",  32'(perr_b),  32'd0);
    checkOutput("par_ok_ferr",  32'(ferr_b),  32'd0);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;
    sendFrame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (DIV_B) @(negedge clk);
    checkOutput("par_bad_data",   32'(data_b),   32'h07);
    checkOutput("par_bad_perr",   32'(perr_b),   32'd1);
    checkOutput("par_bad_frames", 32'(frames_b), 32'd2);

    // Seventeen back-to-back frames into a 16-deep FIFO with no consumer.
    doReset();
    for (int i = 0; i <= 16; i++) sendFrame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ovf_fcnt",   32'(fcnt_a),   32'd16);
    checkOutput("ovf_flag",   32'(ovf_a),    32'd1);
    checkOutput("ovf_head",   32'(data_a),   32'h00);
    checkOutput("ovf_frames", 32'(frames_a), 32'd16);
    popA();
    checkOutput("ovf_next_head", 32'(data_a), 32'h01);
    checkOutput("ovf_after_pop", 32'(fcnt_a), 32'd15);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    checkOutput("clr_fcnt",   32'(fcnt_a),   32'd0);
    checkOutput("clr_ovf",    32'(ovf_a),    32'd0);
    checkOutput("clr_valid",  32'(valid_a),  32'd0);
    checkOutput("clr_frames", 32'(frames_a), 32'd16);

    // Reset in the middle of the data bits of 0xF0, then a clean 0x12.
    repeat (DIV_A) @(negedge clk);
    driveBit(1'b0, 1'b0, DIV_A);
    driveBit(1'b0, 1'b0, DIV_A);
    driveBit(1'b0, 1'b0, 100);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst_frames", 32'(frames_a), 32'd0);
    checkOutput("midrst_fcnt",   32'(fcnt_a),   32'd0);
    rst_n = 1'b1;
    repeat (3 * DIV_A) @(negedge clk);
    checkOutput("midrst_nopush", 32'(fcnt_a), 32'd0);
    sendFrame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    repeat (DIV_A) @(negedge clk);
    checkOutput("after_rst_fcnt",   32'(fcnt_a),   32'd1);
    checkOutput("after_rst_data",   32'(data_a),   32'h12);
    checkOutput("after_rst_ferr",   32'(ferr_a),   32'd0);
    checkOutput("after_rst_frames", 32'(frames_a), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
